instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  - Initiator side of the instruction-memory interface.
//  - Owns the 64-bit PC and presents it to the combinational instruction memory.
//  - Captures the returned 32-bit word into the IF/ID pipeline register.
//  - Handles stall, flush, branch redirect and halt for the ARM (LEGv8) pipeline; sits between instruction memory and decode.
// PARAMETERS
//  - RESET_PC   64'h0           PC loaded on reset; first fetch address.
//  - PC_INC     64'd4           sequential PC increment (bytes).
//  - CNT_W      32              width of the fetched-instruction counter.
// PORTS
//  - clk           in   1      single clock; all state updates on posedge.
//  - rst           in   1      asynchronous, active-high reset.
//  - imem_pc       out  64     fetch address to instruction memory (= pc_q).
//  - imem_instr    in   32     instruction word; valid combinationally in the same cycle as imem_pc.
//  - stall         in   1      decode hazard; hold PC and IF/ID.
//  - flush         in   1      invalidate IF/ID contents (inject NOP).
//  - br_taken      in   1      redirect request (B/CBZ resolved).
//  - br_target     in   64     redirect address.
//  - halt          in   1      stop fetching after the current cycle.
//  - ifid_instr    out  32     registered instruction to decode.
//  - ifid_pc       out  64     PC of ifid_instr.
//  - ifid_valid    out  1      ifid_instr is a real fetched instruction.
//  - fetch_count   out  CNT_W  number of instructions written valid into IF/ID.
//  - halted        out  1      FSM is in HALTED.
// BEHAVIOUR
//  - Reset values (async):
//    - pc_q=RESET_PC; state=BOOT.
//    - ifid_instr=NOP; ifid_pc=0; ifid_valid=0.
//    - fetch_count=0; halted=0.
//  - FSM states and transitions:
//    - BOOT: one cycle after reset release. No capture; ifid_valid=0; PC holds. Next state RUN.
//    - RUN, priority br_taken > halt > stall > normal:
//      - br_taken: pc_q<=br_target; ifid_valid<=0 (wrong-path kill). Overrides stall and flush.
//      - halt: go to HALTED; current word is still captured if not stalled.
//      - stall: pc_q and all IF/ID registers hold. If flush is also high, ifid_valid<=0 and the instr is forced to NOP.
//      - normal: ifid_instr<=imem_instr; ifid_pc<=pc_q; ifid_valid<=~flush; pc_q<=pc_q+PC_INC.
//    - HALTED: PC frozen; ifid_valid<=0; halted=1. br_taken loads br_target and returns to RUN. halt/stall ignored.
//  - Latency: one cycle from imem_pc to ifid_instr; redirect takes effect on the next fetch (1 bubble).
//  - Arithmetic: PC add is 64-bit modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0, with no flag.
//  - fetch_count increments when ifid_valid is written 1; wraps modulo 2^CNT_W.
//  - Reset asserted mid-operation returns all outputs to reset values immediately (async).
// CONFIGURATION
//  - Macro FETCH_ALIGN_CHECK_EN.
//  - Defined: adds output port align_fault (1 bit, reset 0).
//    - A capture with pc_q[1:0]!=0 writes ifid_valid<=0 and instr=NOP, sets align_fault=1 and enters HALTED.
//    - align_fault is sticky until rst.
//    - br_target[1:0]!=0 is loaded; the fault is raised on the next capture.
//  - Undefined: no port; PC[1:0] ignored; all addresses fetched.
// STRUCTURE
//  - Package arm_cpu_pkg:
//    - INSTR_W=32, ADDR_W=64.
//    - NOP_INSTR=32'h8B1F03FF (ADD XZR,XZR,XZR).
//    - fetch_state_t enum {BOOT, RUN, HALTED}.
//  - Sub-module fetch_pc_reg: PC register with next-PC mux (target/inc/hold). FSM and IF/ID register stay in the top.
// TESTING
//  - Reset then run 4 cycles with no stall:
//    - imem_pc sequence 0,0,4,8,12 (BOOT holds).
//    - ifid_pc 0,4,8 with ifid_valid=1; fetch_count=3.
//  - stall held 2 cycles at pc=8:
//    - imem_pc stays 8; ifid unchanged; fetch_count unchanged.
//    - On release, pc goes to 12.
//  - br_taken with br_target=64'h40 while stall=1:
//    - next cycle imem_pc=64'h40 and ifid_valid=0.
//    - following cycle ifid_pc=64'h40.
//  - halt at pc=16:
//    - halted=1; PC frozen at 20; ifid_valid=0.
//    - br_taken with target 64'h100 resumes fetching at 64'h100.
//  - Wrap: force pc to 64'hFFFF_FFFF_FFFF_FFFC via redirect; next imem_pc=0.
//  - With FETCH_ALIGN_CHECK_EN: redirect to 64'h6.
//    - align_fault=1 after capture; halted=1; ifid_valid=0.
//    - align_fault clears only on rst.

Source files
------------

// File: rtl/arm_cpu_pkg.sv
// -----------------------------------------------------------------------------
// arm_cpu_pkg
// Shared types and constants for the LEGv8 pipeline front end.
//   INSTR_W / ADDR_W : instruction word and address widths
//   NOP_INSTR        : ADD XZR,XZR,XZR, injected into IF/ID on flush/kill
//   fetch_state_t    : fetch sequencer states
//   pc_sel_t         : next-PC source select for fetch_pc_reg
// -----------------------------------------------------------------------------
package arm_cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h8B1F03FF;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_SEQ    = 2'd1,
    PC_TARGET = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_if
// Instruction-memory bus between the fetch unit (master) and a combinational
// instruction memory (slave).
//   imem_pc    : fetch address, driven by the master
//   imem_instr : instruction word, valid in the same cycle as imem_pc
// -----------------------------------------------------------------------------
interface instruction_fetch_unit_if;
  import arm_cpu_pkg::*;

  logic [ADDR_W-1:0]  imem_pc;
  logic [INSTR_W-1:0] imem_instr;

  modport master (output imem_pc, input  imem_instr);
  modport slave  (input  imem_pc, output imem_instr);

endinterface

// File: rtl/fetch_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg
// Program counter register with a three-way next-PC mux.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (loads RESET_PC)
//   pc_sel     : PC_HOLD keeps, PC_SEQ adds PC_INC, PC_TARGET loads br_target
//   br_target  : redirect address
//   pc_q       : current PC
// -----------------------------------------------------------------------------
module fetch_pc_reg
  import arm_cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
  parameter logic [ADDR_W-1:0] PC_INC   = 64'd4
) (
  input  logic              clk,
  input  logic              rst,
  input  pc_sel_t           pc_sel,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc_q
);

  // Plain modulo-2^64 add: the top of the address space wraps to 0 silently.
  function automatic logic [ADDR_W-1:0] pc_add(input logic [ADDR_W-1:0] a,
                                               input logic [ADDR_W-1:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      case (pc_sel)
        PC_SEQ:    pc_q <= pc_add(pc_q, PC_INC);
        PC_TARGET: pc_q <= br_target;
        default:   pc_q <= pc_q;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage of the LEGv8 pipeline: owns the PC, drives the instruction
// memory and captures the returned word into the IF/ID register.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   imem         : master side of the instruction-memory bus (pc out, instr in)
//   stall        : hold PC and IF/ID
//   flush        : invalidate IF/ID (NOP)
//   br_taken     : redirect to br_target, kills the wrong-path word
//   br_target    : redirect address
//   halt         : stop fetching after the current cycle
//   ifid_instr   : registered instruction for decode
//   ifid_pc      : PC of ifid_instr
//   ifid_valid   : ifid_instr is a real fetched instruction
//   fetch_count  : number of instructions written valid into IF/ID
//   halted       : fetch sequencer is in HALTED
//   align_fault  : sticky misaligned-fetch flag (only with FETCH_ALIGN_CHECK_EN)
// Build option: define FETCH_ALIGN_CHECK_EN to trap fetches from PCs whose
// low two bits are non-zero.
// -----------------------------------------------------------------------------
module instruction_fetch_unit
  import arm_cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
  parameter logic [ADDR_W-1:0] PC_INC   = 64'd4,
  parameter int                CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  instruction_fetch_unit_if.master imem,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     br_taken,
  input  logic [ADDR_W-1:0]        br_target,
  input  logic                     halt,
  output logic [INSTR_W-1:0]       ifid_instr,
  output logic [ADDR_W-1:0]        ifid_pc,
  output logic                     ifid_valid,
  output logic [CNT_W-1:0]         fetch_count,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic                     align_fault,
`endif
  output logic                     halted
);

  fetch_state_t       state_q, state_d;
  pc_sel_t            pc_sel;
  logic [ADDR_W-1:0]  pc_q;

  logic [INSTR_W-1:0] instr_p1;
  logic [ADDR_W-1:0]  pc_p1;
  logic               vld_p1;
  logic [CNT_W-1:0]   cnt_q;

  logic               cap;       // load IF/ID instr/pc this cycle
  logic               force_nop; // write NOP into the IF/ID instruction
  logic               vld_d;     // next IF/ID valid
  logic               fault_set;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .pc_sel    (pc_sel),
    .br_target (br_target),
    .pc_q      (pc_q)
  );

  assign imem.imem_pc = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pc_sel    = PC_HOLD;
    cap       = 1'b0;
    force_nop = 1'b0;
    vld_d     = vld_p1;
    fault_set = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        vld_d   = 1'b0;
      end
      RUN: begin
        if (br_taken) begin
          // Redirect beats halt, stall and flush; the word in flight is wrong-path.
          pc_sel = PC_TARGET;
          vld_d  = 1'b0;
        end else begin
          if (halt) state_d = HALTED;
          if (stall) begin
            if (flush) begin
              vld_d     = 1'b0;
              force_nop = 1'b1;
            end
          end else
`ifdef FETCH_ALIGN_CHECK_EN
          if (|pc_q[1:0]) begin
            cap       = 1'b1;
            force_nop = 1'b1;
            vld_d     = 1'b0;
            fault_set = 1'b1;
            state_d   = HALTED;
          end else
`endif
          begin
            cap    = 1'b1;
            vld_d  = ~flush;
            pc_sel = PC_SEQ;
          end
        end
      end
      HALTED: begin
        vld_d = 1'b0;
        if (br_taken) begin
          pc_sel  = PC_TARGET;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
        vld_d   = 1'b0;
      end
    endcase
  end

  // ---- IF/ID register (stage 1) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_p1 <= NOP_INSTR;
      pc_p1    <= '0;
      vld_p1   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (cap) begin
        instr_p1 <= force_nop ? NOP_INSTR : imem.imem_instr;
        pc_p1    <= pc_q;
      end else if (force_nop) begin
        instr_p1 <= NOP_INSTR;
      end
      vld_p1 <= vld_d;
      if (cap && vld_d) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky until reset so software/debug can see why fetch stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            align_fault <= 1'b0;
    else if (fault_set) align_fault <= 1'b1;
  end
`else
  logic unused_fault;
  assign unused_fault = fault_set;
`endif

  assign ifid_instr  = instr_p1;
  assign ifid_pc     = pc_p1;
  assign ifid_valid  = vld_p1;
  assign fetch_count = cnt_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  import arm_cpu_pkg::*;

  localparam int CNT_W = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall, flush, br_taken, halt;
  logic [ADDR_W-1:0]  br_target;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0]  ifid_pc;
  logic               ifid_valid;
  logic [CNT_W-1:0]   fetch_count;
  logic               halted;
`ifdef FETCH_ALIGN_CHECK_EN
  logic               align_fault;
`endif

  instruction_fetch_unit_if imem ();

  instruction_fetch_unit #(
    .RESET_PC (64'h0),
    .PC_INC   (64'd4),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem),
    .stall       (stall),
    .flush       (flush),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .halt        (halt),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .ifid_valid  (ifid_valid),
    .fetch_count (fetch_count),
`ifdef FETCH_ALIGN_CHECK_EN
    .align_fault (align_fault),
`endif
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Instruction memory model: word is a fixed function of the address.
  function automatic logic [31:0] mem_f(input logic [63:0] a);
    return {a[15:0] ^ 16'h9100, ~a[15:0]};
  endfunction

  assign imem.imem_instr = mem_f(imem.imem_pc);

  typedef struct {
    logic [3:0]  ctl;    // {stall, flush, br_taken, halt}
    logic [63:0] tgt;
    logic [63:0] e_pc;   // imem_pc after the edge
    logic [63:0] e_ifpc;
    logic [31:0] e_cnt;
    logic [2:0]  e_f;    // {ifid_valid, halted, ifid_instr must be NOP}
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } sb_t;

  int          checks = 0;
  int          errors = 0;
  sb_t         sbq[$];
  logic [31:0] prev_cnt;
  vec_t        tbl[18];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ctl, input logic [63:0] tgt);
    {stall, flush, br_taken, halt} = ctl;
    br_target = tgt;
  endtask

  task automatic push(input logic [63:0] pc);
    sb_t e;
    e.pc    = pc;
    e.instr = mem_f(pc);
    sbq.push_back(e);
  endtask

  // One clock; sample 1 time unit after the edge and retire scoreboard
  // entries whenever the DUT reports a new valid capture.
  task automatic step();
    sb_t e;
    @(posedge clk);
    #1;
    if (!rst && fetch_count != prev_cnt) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_capture actual=%h required=none", ifid_pc);
      end else begin
        e = sbq.pop_front();
        chk("sb_ifid_pc", ifid_pc, e.pc);
        chk("sb_ifid_instr", 64'(ifid_instr), 64'(e.instr));
      end
    end
    prev_cnt = fetch_count;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0000, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    prev_cnt = '0;
  endtask

  initial begin
    logic [31:0] last_cnt;

    tbl[0]  = '{4'b0000, 64'h0,  64'h0,   64'h0,  32'd0, 3'b001};
    tbl[1]  = '{4'b0000, 64'h0,  64'h4,   64'h0,  32'd1, 3'b100};
    tbl[2]  = '{4'b0000, 64'h0,  64'h8,   64'h4,  32'd2, 3'b100};
    tbl[3]  = '{4'b0000, 64'h0,  64'hC,   64'h8,  32'd3, 3'b100};
    tbl[4]  = '{4'b1000, 64'h0,  64'hC,   64'h8,  32'd3, 3'b100};
    tbl[5]  = '{4'b1000, 64'h0,  64'hC,   64'h8,  32'd3, 3'b100};
    tbl[6]  = '{4'b0000, 64'h0,  64'h10,  64'hC,  32'd4, 3'b100};
    tbl[7]  = '{4'b1100, 64'h0,  64'h10,  64'hC,  32'd4, 3'b001};
    tbl[8]  = '{4'b1010, 64'h40, 64'h40,  64'hC,  32'd4, 3'b000};
    tbl[9]  = '{4'b0000, 64'h0,  64'h44,  64'h40, 32'd5, 3'b100};
    tbl[10] = '{4'b0100, 64'h0,  64'h48,  64'h44, 32'd5, 3'b000};
    tbl[11] = '{4'b0001, 64'h0,  64'h4C,  64'h48, 32'd6, 3'b110};
    tbl[12] = '{4'b1001, 64'h0,  64'h4C,  64'h48, 32'd6, 3'b010};
    tbl[13] = '{4'b0010, 64'h100, 64'h100, 64'h48, 32'd6, 3'b000};
    tbl[14] = '{4'b0000, 64'h0,  64'h104, 64'h100, 32'd7, 3'b100};
    tbl[15] = '{4'b0011, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'h100, 32'd7, 3'b000};
    tbl[16] = '{4'b0000, 64'h0,  64'h0,   64'hFFFF_FFFF_FFFF_FFFC, 32'd8, 3'b100};
    tbl[17] = '{4'b0000, 64'h0,  64'h4,   64'h0,  32'd9, 3'b100};

    do_reset();

    chk("rst_imem_pc", imem.imem_pc, 64'h0);
    chk("rst_ifid_instr", 64'(ifid_instr), 64'(NOP_INSTR));
    chk("rst_ifid_pc", ifid_pc, 64'h0);
    chk("rst_ifid_valid", 64'(ifid_valid), 64'h0);
    chk("rst_fetch_count", 64'(fetch_count), 64'h0);
    chk("rst_halted", 64'(halted), 64'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_align_fault", 64'(align_fault), 64'h0);
`endif

    last_cnt = 32'd0;
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].ctl, tbl[i].tgt);
      if (tbl[i].e_cnt != last_cnt) push(tbl[i].e_ifpc);
      last_cnt = tbl[i].e_cnt;
      step();
      chk($sformatf("v%0d_imem_pc", i), imem.imem_pc, tbl[i].e_pc);
      chk($sformatf("v%0d_ifid_pc", i), ifid_pc, tbl[i].e_ifpc);
      chk($sformatf("v%0d_ifid_valid", i), 64'(ifid_valid), 64'(tbl[i].e_f[2]));
      chk($sformatf("v%0d_fetch_count", i), 64'(fetch_count), 64'(tbl[i].e_cnt));
      chk($sformatf("v%0d_halted", i), 64'(halted), 64'(tbl[i].e_f[1]));
      if (tbl[i].e_f[0]) chk($sformatf("v%0d_nop", i), 64'(ifid_instr), 64'(NOP_INSTR));
    end
    chk("sb_drained", 64'(sbq.size()), 64'h0);

    // Asynchronous reset in the middle of a cycle.
    drive(4'b0000, 64'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_imem_pc", imem.imem_pc, 64'h0);
    chk("arst_ifid_valid", 64'(ifid_valid), 64'h0);
    chk("arst_fetch_count", 64'(fetch_count), 64'h0);
    chk("arst_ifid_instr", 64'(ifid_instr), 64'(NOP_INSTR));
    chk("arst_ifid_pc", ifid_pc, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_cnt = '0;
    step();
    chk("boot_imem_pc", imem.imem_pc, 64'h0);
    chk("boot_ifid_valid", 64'(ifid_valid), 64'h0);
    push(64'h0);
    step();
    chk("post_arst_imem_pc", imem.imem_pc, 64'h4);
    chk("post_arst_fetch_count", 64'(fetch_count), 64'h1);

`ifdef FETCH_ALIGN_CHECK_EN
    // Redirect to a misaligned target: loaded, faults on the next capture.
    drive(4'b0010, 64'h6);
    step();
    chk("al_imem_pc", imem.imem_pc, 64'h6);
    chk("al_fault_pre", 64'(align_fault), 64'h0);
    drive(4'b0000, 64'h0);
    step();
    chk("al_fault", 64'(align_fault), 64'h1);
    chk("al_halted", 64'(halted), 64'h1);
    chk("al_ifid_valid", 64'(ifid_valid), 64'h0);
    chk("al_nop", 64'(ifid_instr), 64'(NOP_INSTR));
    chk("al_count", 64'(fetch_count), 64'h1);
    drive(4'b0010, 64'h200);
    step();
    chk("al_resume_pc", imem.imem_pc, 64'h200);
    chk("al_resume_halted", 64'(halted), 64'h0);
    drive(4'b0000, 64'h0);
    push(64'h200);
    step();
    chk("al_sticky", 64'(align_fault), 64'h1);
    chk("al_resume_valid", 64'(ifid_valid), 64'h1);
    do_reset();
    chk("al_cleared", 64'(align_fault), 64'h0);
`endif

    chk("sb_drained_end", 64'(sbq.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
